// File: rtl/cwe_counter.sv
// cwe_counter: enable-gated up-counter that wraps modulo 2^WIDTH and flags the all-ones terminal count
module cwe_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             tc
);
   always_ff @(posedge clk)
      if (reset) count <= '0;
      else if (enable) count <= count + 1'b1;
   assign tc = &count;
endmodule

// File: tb/tb_cwe_counter.sv
// tb_cwe_counter: directed steps with hand-computed expectations for cwe_counter
module tb_cwe_counter;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] count;
   logic       tc;
   int         errors = 0;
   int         checks = 0;

   cwe_counter #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .enable(enable), .count(count), .tc(tc));

   always #10 clk = ~clk;

   task automatic step(input logic r, input logic e);
      reset = r;
      enable = e;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] exp_count, input logic exp_tc);
      checks++;
      assert (count === exp_count) else begin
         errors++;
         $error("FAIL %s count observed=%0d expected=%0d", tag, count, exp_count);
      end
      checks++;
      assert (tc === exp_tc) else begin
         errors++;
         $error("FAIL %s tc observed=%0b expected=%0b", tag, tc, exp_tc);
      end
   endtask

   initial begin
      step(1'b1, 1'b0);
      check("reset", 4'd0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         step(1'b0, 1'b1);
         check($sformatf("count%0d", i), 4'(i), 1'b0);
      end
      step(1'b0, 1'b0);
      check("hold1", 4'd5, 1'b0);
      step(1'b0, 1'b0);
      check("hold2", 4'd5, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check("reenable", 4'd8, 1'b0);
      step(1'b1, 1'b1);
      check("reset_mid", 4'd0, 1'b0);
      step(1'b0, 1'b1);
      check("resume1", 4'd1, 1'b0);
      step(1'b0, 1'b1);
      check("resume2", 4'd2, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("reset_held", 4'd0, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 1'b1);
         check($sformatf("wrap%0d", i), 4'(i % 16), i == 15);
      end
      step(1'b0, 1'b1);
      check("after_wrap", 4'd1, 1'b0);
      for (int i = 2; i <= 15; i++) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check("tc_hold", 4'd15, 1'b1);
      step(1'b0, 1'b0);
      check("tc_hold2", 4'd15, 1'b1);
      step(1'b1, 1'b0);
      for (int i = 1; i <= 7; i++) step(1'b0, 1'b1);
      check("pre_priority", 4'd7, 1'b0);
      step(1'b1, 1'b1);
      check("priority", 4'd0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b1, 1'bx);
      check("reset_x_enable", 4'd0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
